// File: rtl/j1_loader_if.sv
// Byte-stream and RAM write-port bundle for the J1 boot/reload loader.
// The host link side (rx_*) and the program RAM write port (ram_*) travel
// together because the loader is the only thing between them.
interface j1_loader_if;

    // host byte link
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    // dedicated RAM write port (8K x 16)
    logic [12:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_we;

    // master: host byte source / RAM, i.e. everything outside the loader
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  ram_addr,
        input  ram_data,
        input  ram_we
    );

    // slave: the loader itself
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output ram_addr,
        output ram_data,
        output ram_we
    );

endinterface

// File: rtl/j1_loader.sv
// j1_loader: holds the J1 in reset while a program image arrives as a byte
// frame (LEN_LO, LEN_HI, N words lo/hi, CHK), writes each word into program
// RAM, checks the XOR checksum and then releases the CPU to run from 0.
module j1_loader #(
    parameter bit          AUTOLOAD = 1'b1,
    parameter int unsigned TIMEOUT  = 1_000_000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    j1_loader_if.slave  bus,
    input  logic        load_req,
    output logic        cpu_rst_o,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Timer wide enough to hold TIMEOUT-1; a 1-bit dummy when the timeout is off.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
        S_CHK,
        S_RUN,
        S_ERROR
    } state_t;

    localparam state_t RESET_STATE = AUTOLOAD ? S_LEN_LO : S_IDLE;

    state_t        state_q, state_d;
    logic [15:0]   wordCount_q, wordCount_d;
    logic [15:0]   wordIdx_q, wordIdx_d;
    logic [7:0]    loByte_q, loByte_d;
    logic [15:0]   dataWord_q, dataWord_d;
    logic [7:0]    xor_q, xor_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          rxReady_q, rxReady_d;
    logic          busy_q, busy_d;
    logic          cpuRst_q, cpuRst_d;
    logic          ramWe_q, ramWe_d;

    logic          accept;
    logic [15:0]   lastIdx;
    logic          timedState;
    logic          timeoutHit;

    assign accept     = rxReady_q & bus.rx_valid;
    assign lastIdx    = wordCount_q - 16'd1;
    assign timedState = (state_q == S_LEN_HI) || (state_q == S_DATA_LO) ||
                        (state_q == S_DATA_HI) || (state_q == S_CHK);
    assign timeoutHit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    // Next-state, frame bookkeeping and registered-output decode for the loader FSM.
    always_comb begin
        state_d     = state_q;
        wordCount_d = wordCount_q;
        wordIdx_d   = wordIdx_q;
        loByte_d    = loByte_q;
        dataWord_d  = dataWord_q;
        xor_d       = xor_q;
        timer_d     = '0;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_LEN_LO: begin
                if (accept) begin
                    wordCount_d[7:0] = bus.rx_data;
                    xor_d            = xor_q ^ bus.rx_data;
                    state_d          = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    wordCount_d[15:8] = bus.rx_data;
                    xor_d             = xor_q ^ bus.rx_data;
                    if ({bus.rx_data, wordCount_q[7:0]} == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    loByte_d = bus.rx_data;
                    xor_d    = xor_q ^ bus.rx_data;
                    state_d  = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    dataWord_d = {bus.rx_data, loByte_q};
                    xor_d      = xor_q ^ bus.rx_data;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wordIdx_q == lastIdx) begin
                    state_d = S_CHK;
                end else begin
                    wordIdx_d = wordIdx_q + 16'd1;
                    state_d   = S_DATA_LO;
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (bus.rx_data == xor_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_RUN, S_ERROR: begin
                if (load_req) begin
                    state_d   = S_LEN_LO;
                    wordIdx_d = '0;
                    xor_d     = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // An accepted byte always wins over an expiring timer.
        if (timedState && !accept) begin
            if (timeoutHit) begin
                state_d = S_ERROR;
                error_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        rxReady_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                    (state_d == S_DATA_LO) || (state_d == S_DATA_HI) ||
                    (state_d == S_CHK);
        busy_d    = rxReady_d || (state_d == S_WRITE);
        cpuRst_d  = (state_d != S_RUN);
        ramWe_d   = (state_d == S_WRITE);
    end

    // State and output registers; outputs hold their quiet values while reset is held.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= RESET_STATE;
            wordCount_q <= '0;
            wordIdx_q   <= '0;
            loByte_q    <= '0;
            dataWord_q  <= '0;
            xor_q       <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rxReady_q   <= 1'b0;
            busy_q      <= 1'b0;
            cpuRst_q    <= 1'b1;
            ramWe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wordCount_q <= wordCount_d;
            wordIdx_q   <= wordIdx_d;
            loByte_q    <= loByte_d;
            dataWord_q  <= dataWord_d;
            xor_q       <= xor_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rxReady_q   <= rxReady_d;
            busy_q      <= busy_d;
            cpuRst_q    <= cpuRst_d;
            ramWe_q     <= ramWe_d;
        end
    end

    assign bus.rx_ready = rxReady_q;
    assign bus.ram_we   = ramWe_q;
    assign bus.ram_addr = wordIdx_q[12:0];
    assign bus.ram_data = dataWord_q;
    assign cpu_rst_o    = cpuRst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_j1_loader.sv
// Testbench for j1_loader: drives byte frames over the host link and checks
// every RAM write against a scoreboard of expected (address, data) pairs,
// plus release/error/timeout behaviour and the AUTOLOAD=0 start-up path.
module tb_j1_loader;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic sysRst;
    logic loadReq;
    logic cpuRst, busyO, doneO, errorO;
    logic cpuRst2, busy2, done2, error2;

    int   vectorCount = 0;
    int   missCount   = 0;
    int   writeCount  = 0;
    logic prevWe      = 1'b0;

    wr_t         expQ[$];
    logic [15:0] frameWords[$];

    j1_loader_if bus ();
    j1_loader_if bus2 ();

    j1_loader #(.AUTOLOAD(1'b1), .TIMEOUT(16)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (sysRst),
        .bus       (bus),
        .load_req  (loadReq),
        .cpu_rst_o (cpuRst),
        .busy      (busyO),
        .done      (doneO),
        .error     (errorO)
    );

    j1_loader #(.AUTOLOAD(1'b0)) dutNoAuto (
        .sys_clk_i (clk),
        .sys_rst_i (sysRst),
        .bus       (bus2),
        .load_req  (1'b0),
        .cpu_rst_o (cpuRst2),
        .busy      (busy2),
        .done      (done2),
        .error     (error2)
    );

    // 10 ns clock shared by both loaders
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // RAM write monitor: each strobe must match the oldest expected write,
    // last exactly one cycle, and coincide with rx_ready being low.
    always @(negedge clk) begin
        if (!sysRst) begin
            if (bus.ram_we) begin
                writeCount++;
                checkOutput("we_pulse_width", {31'd0, prevWe}, 32'd0);
                checkOutput("rdy_low_in_write", {31'd0, bus.rx_ready}, 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    checkOutput("ram_addr", {19'd0, bus.ram_addr}, {19'd0, e.addr});
                    checkOutput("ram_data", {16'd0, bus.ram_data}, {16'd0, e.data});
                end
            end else if (busyO && !bus.rx_ready) begin
                checkOutput("rdy_low_outside_write", 32'd1, 32'd0);
            end
        end
        prevWe = bus.ram_we;
    end

    // Offer one byte after 'gap' idle cycles and hold it until accepted.
    // Starts and ends 1 ns after a rising edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit accepted = 0;
        int waitCnt  = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!accepted && waitCnt < 64) begin
            @(negedge clk);
            if (bus.rx_ready) accepted = 1;
            @(posedge clk);
            #1;
            waitCnt++;
        end
        bus.rx_valid = 1'b0;
        if (!accepted) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // Send a full frame built from frameWords; expected writes go to the scoreboard.
    task automatic sendFrame(input int gap, input bit badChk);
        logic [7:0]  x;
        logic [15:0] n;
        logic [15:0] w;
        x = 8'h00;
        n = 16'(frameWords.size());
        applyStimulus(n[7:0], gap);
        x ^= n[7:0];
        applyStimulus(n[15:8], gap);
        x ^= n[15:8];
        for (int i = 0; i < frameWords.size(); i++) begin
            wr_t e;
            w = frameWords[i];
            applyStimulus(w[7:0], gap);
            e.addr = 13'(i);
            e.data = w;
            expQ.push_back(e);
            applyStimulus(w[15:8], gap);
            x ^= w[7:0] ^ w[15:8];
        end
        applyStimulus(badChk ? (x ^ 8'h01) : x, gap);
    endtask

    task automatic fillWords(input int n, input int seed);
        frameWords.delete();
        for (int i = 0; i < n; i++) frameWords.push_back(16'((i * 32'h2f1b) ^ seed));
    endtask

    // One-cycle load request; afterwards the loader sits in LEN_LO with flags cleared.
    task automatic pulseLoad();
        loadReq = 1'b1;
        @(posedge clk);
        #1;
        loadReq = 1'b0;
        checkOutput("load_busy", {31'd0, busyO}, 32'd1);
        checkOutput("load_done_clr", {31'd0, doneO}, 32'd0);
        checkOutput("load_err_clr", {31'd0, errorO}, 32'd0);
        checkOutput("load_cpu_held", {31'd0, cpuRst}, 32'd1);
    endtask

    task automatic checkReleased(input string tag);
        checkOutput({tag, "_cpu_rst"}, {31'd0, cpuRst}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, doneO}, 32'd1);
        checkOutput({tag, "_error"}, {31'd0, errorO}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busyO}, 32'd0);
        checkOutput({tag, "_sb_drain"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int cycles;
        int wrBefore;
        sysRst        = 1'b1;
        loadReq       = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus2.rx_valid = 1'b0;
        bus2.rx_data  = 8'h00;

        // reset values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cpu_rst", {31'd0, cpuRst}, 32'd1);
        checkOutput("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        checkOutput("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        checkOutput("rst_ram_addr", {19'd0, bus.ram_addr}, 32'd0);
        checkOutput("rst_ram_data", {16'd0, bus.ram_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busyO}, 32'd0);
        checkOutput("rst_done", {31'd0, doneO}, 32'd0);
        checkOutput("rst_error", {31'd0, errorO}, 32'd0);
        checkOutput("rst2_cpu_rst", {31'd0, cpuRst2}, 32'd1);
        @(posedge clk);
        #1;
        sysRst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        checkOutput("post_rst_busy", {31'd0, busyO}, 32'd1);
        checkOutput("post_rst_cpu_rst", {31'd0, cpuRst}, 32'd1);
        checkOutput("noauto_release", {31'd0, cpuRst2}, 32'd0);
        checkOutput("noauto_rx_ready", {31'd0, bus2.rx_ready}, 32'd0);
        checkOutput("noauto_busy", {31'd0, busy2}, 32'd0);
        checkOutput("noauto_done", {31'd0, done2}, 32'd0);

        // two-word frame 02 00 34 12 CD AB, checksum 8'h42
        frameWords = {16'h1234, 16'hABCD};
        sendFrame(0, 1'b0);
        checkReleased("good2");

        // same frame with a corrupted checksum, then recover
        pulseLoad();
        frameWords = {16'h1234, 16'hABCD};
        sendFrame(0, 1'b1);
        checkOutput("bad_error", {31'd0, errorO}, 32'd1);
        checkOutput("bad_done", {31'd0, doneO}, 32'd0);
        checkOutput("bad_cpu_rst", {31'd0, cpuRst}, 32'd1);
        checkOutput("bad_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bad_hold_cpu_rst", {31'd0, cpuRst}, 32'd1);
        pulseLoad();
        fillWords(3, 16'h5a5a);
        sendFrame(0, 1'b0);
        checkReleased("recover");

        // empty image: no writes at all
        pulseLoad();
        wrBefore = writeCount;
        frameWords.delete();
        sendFrame(0, 1'b0);
        checkReleased("n0");
        checkOutput("n0_no_writes", 32'(writeCount - wrBefore), 32'd0);

        // bubbled host: one byte every third cycle
        pulseLoad();
        fillWords(4, 16'h0f0f);
        sendFrame(2, 1'b0);
        checkReleased("bubble");

        // back-to-back host that keeps offering during WRITE
        pulseLoad();
        wrBefore = writeCount;
        fillWords(5, 16'hc3a1);
        sendFrame(0, 1'b0);
        checkReleased("b2b");
        checkOutput("b2b_writes", 32'(writeCount - wrBefore), 32'd5);

        // timeout after LEN_HI: ERROR 16 cycles after the last accepted byte
        pulseLoad();
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        cycles = 0;
        while (!errorO && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("timeout_cycles", 32'(cycles), 32'd16);
        checkOutput("timeout_cpu_rst", {31'd0, cpuRst}, 32'd1);
        checkOutput("timeout_busy", {31'd0, busyO}, 32'd0);

        // idle host in LEN_LO never times out
        pulseLoad();
        repeat (100) @(posedge clk);
        #1;
        checkOutput("idle_error", {31'd0, errorO}, 32'd0);
        checkOutput("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // 8193 words: the last one wraps onto address 0
        wrBefore = writeCount;
        fillWords(8193, 16'h7e11);
        sendFrame(0, 1'b0);
        checkReleased("wrap");
        checkOutput("wrap_writes", 32'(writeCount - wrBefore), 32'd8193);

        // reset in the middle of a frame abandons it
        pulseLoad();
        applyStimulus(8'h05, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h11, 0);
        sysRst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_cpu_rst", {31'd0, cpuRst}, 32'd1);
        checkOutput("midrst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busyO}, 32'd0);
        sysRst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_cpu_held", {31'd0, cpuRst}, 32'd1);
        checkOutput("midrst_relen_lo", {31'd0, bus.rx_ready}, 32'd1);
        checkOutput("midrst_done", {31'd0, doneO}, 32'd0);
        frameWords = {16'hBEEF, 16'h0001};
        sendFrame(0, 1'b0);
        checkReleased("after_midrst");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
